// File: rtl/sys_ctrl_tx.sv
// sys_ctrl_tx
// Response path of the system controller (REF_CLK domain). Register-file
// reads and ALU results arrive as single-cycle send pulses. Each source has a
// one-deep pend/hold buffer. The transmit FSM writes the captured data into
// the TX async FIFO one byte per frame: one frame for RF data, two frames for
// ALU results, LSB first.
//
// Ports:
//   CLK        reference clock, rising edge
//   RST        asynchronous active-low reset
//   RF_SEND    pulse: RF_DATA valid this cycle
//   RF_DATA    register-file read data (WIDTH)
//   ALU_SEND   pulse: ALU_DATA valid this cycle
//   ALU_DATA   ALU result (2*WIDTH)
//   FIFO_FULL  TX FIFO full, already synchronised to CLK
//   WR_INC     FIFO write strobe
//   WR_DATA    FIFO write data (WIDTH)
//   BUSY       FSM not in IDLE
//   OVR        one-cycle pulse: a pending request was overwritten
//   dbg_state  current FSM state, for observation only
//
// FIFO write handshake: the FIFO accepts a byte on every cycle WR_INC is
// high. WR_INC is never high while FIFO_FULL is high. While FIFO_FULL is high,
// WR_DATA and the state hold until a cycle with FIFO_FULL low.
module sys_ctrl_tx #(
    parameter int WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RF_SEND,
    input  logic [WIDTH-1:0]   RF_DATA,
    input  logic               ALU_SEND,
    input  logic [2*WIDTH-1:0] ALU_DATA,
    input  logic               FIFO_FULL,
    output logic               WR_INC,
    output logic [WIDTH-1:0]   WR_DATA,
    output logic               BUSY,
    output logic               OVR,
    output logic [1:0]         dbg_state
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] RF_S      = 2'd1;
    localparam logic [1:0] ALU_LSB_S = 2'd2;
    localparam logic [1:0] ALU_MSB_S = 2'd3;

    logic [1:0]         state;
    logic [1:0]         next_state;
    logic               rf_pend;
    logic [WIDTH-1:0]   rf_hold;
    logic               alu_pend;
    logic [2*WIDTH-1:0] alu_hold;
    logic [2*WIDTH-1:0] tx_reg;
    logic               rf_take;
    logic               alu_take;
    logic               ovr_next;

    // Leaving IDLE consumes the pend flag. RF has fixed priority over ALU.
    assign rf_take  = (state == IDLE) && rf_pend;
    assign alu_take = (state == IDLE) && !rf_pend && alu_pend;

    // Overwrite happens only when the old request is still waiting.
    // A request consumed this cycle is moving into tx_reg, so it is not lost.
    assign ovr_next = (RF_SEND && rf_pend && !rf_take) ||
                      (ALU_SEND && alu_pend && !alu_take);

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE: begin
                if (rf_pend)       next_state = RF_S;
                else if (alu_pend) next_state = ALU_LSB_S;
                else               next_state = IDLE;
            end
            RF_S:      next_state = FIFO_FULL ? RF_S : IDLE;
            ALU_LSB_S: next_state = FIFO_FULL ? ALU_LSB_S : ALU_MSB_S;
            ALU_MSB_S: next_state = FIFO_FULL ? ALU_MSB_S : IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            rf_pend  <= 1'b0;
            rf_hold  <= '0;
            alu_pend <= 1'b0;
            alu_hold <= '0;
            tx_reg   <= '0;
            OVR      <= 1'b0;
        end else begin
            state <= next_state;
            OVR   <= ovr_next;

            // A new send sets the flag and wins over a same-edge clear.
            if (RF_SEND) begin
                rf_pend <= 1'b1;
                rf_hold <= RF_DATA;
            end else if (rf_take) begin
                rf_pend <= 1'b0;
            end

            if (ALU_SEND) begin
                alu_pend <= 1'b1;
                alu_hold <= ALU_DATA;
            end else if (alu_take) begin
                alu_pend <= 1'b0;
            end

            if (rf_take)
                tx_reg[WIDTH-1:0] <= rf_hold;
            else if (alu_take)
                tx_reg <= alu_hold;
        end
    end

    always_comb begin
        WR_DATA = '0;
        case (state)
            RF_S, ALU_LSB_S: WR_DATA = tx_reg[WIDTH-1:0];
            ALU_MSB_S:       WR_DATA = tx_reg[2*WIDTH-1:WIDTH];
            default:         WR_DATA = '0;
        endcase
    end

    assign BUSY      = (state != IDLE);
    assign WR_INC    = (state != IDLE) && !FIFO_FULL;
    assign dbg_state = state;

endmodule

// File: tb/tb_sys_ctrl_tx.sv
// Bench for sys_ctrl_tx: directed scenarios, a queue-based transfer model
// checked on every negative clock edge, and literal checks on the logged
// writes for each scenario.
module tb_sys_ctrl_tx;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        RF_SEND = 1'b0;
  logic [7:0]  RF_DATA = '0;
  logic        ALU_SEND = 1'b0;
  logic [15:0] ALU_DATA = '0;
  logic        FIFO_FULL = 1'b0;
  logic        WR_INC;
  logic [7:0]  WR_DATA;
  logic        BUSY;
  logic        OVR;
  logic [1:0]  dbg_state;

  sys_ctrl_tx #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST),
    .RF_SEND(RF_SEND), .RF_DATA(RF_DATA),
    .ALU_SEND(ALU_SEND), .ALU_DATA(ALU_DATA),
    .FIFO_FULL(FIFO_FULL),
    .WR_INC(WR_INC), .WR_DATA(WR_DATA),
    .BUSY(BUSY), .OVR(OVR), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // transfer model: bytes of the frame(s) in flight plus one pending slot per source
  logic [7:0]  exp_q[$];
  logic        m_rf_v = 1'b0;
  logic [7:0]  m_rf_d = '0;
  logic        m_alu_v = 1'b0;
  logic [15:0] m_alu_d = '0;
  logic        m_ovr = 1'b0;

  initial begin
    forever begin
      @(posedge CLK or negedge RST);
      if (!RST) begin
        exp_q.delete();
        m_rf_v = 1'b0;
        m_alu_v = 1'b0;
        m_ovr = 1'b0;
      end else begin
        m_ovr = 1'b0;
        if (exp_q.size() != 0) begin
          if (!FIFO_FULL) void'(exp_q.pop_front());
        end else if (m_rf_v) begin
          exp_q.push_back(m_rf_d);
          m_rf_v = 1'b0;
        end else if (m_alu_v) begin
          exp_q.push_back(m_alu_d[7:0]);
          exp_q.push_back(m_alu_d[15:8]);
          m_alu_v = 1'b0;
        end
        if (RF_SEND) begin
          if (m_rf_v) m_ovr = 1'b1;
          m_rf_v = 1'b1;
          m_rf_d = RF_DATA;
        end
        if (ALU_SEND) begin
          if (m_alu_v) m_ovr = 1'b1;
          m_alu_v = 1'b1;
          m_alu_d = ALU_DATA;
        end
      end
    end
  end

  // compare process plus write/ovr/busy logging
  logic [7:0] wr_log[$];
  int         wr_cyc[$];
  int         ovr_cnt = 0;
  int         busy_cnt = 0;

  always @(negedge CLK) begin
    logic       e_busy;
    logic [7:0] e_data;
    e_busy = (exp_q.size() != 0);
    e_data = e_busy ? exp_q[0] : 8'h00;
    check("wr_inc", 32'(WR_INC), 32'(e_busy && !FIFO_FULL));
    check("wr_data", 32'(WR_DATA), 32'(e_data));
    check("busy", 32'(BUSY), 32'(e_busy));
    check("ovr", 32'(OVR), 32'(m_ovr));
    if (WR_INC) begin
      wr_log.push_back(WR_DATA);
      wr_cyc.push_back(cyc);
    end
    if (OVR) ovr_cnt++;
    if (BUSY) busy_cnt++;
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    wr_cyc.delete();
    ovr_cnt = 0;
    busy_cnt = 0;
  endtask

  task automatic send(input logic rf, input logic [7:0] rd, input logic alu, input logic [15:0] ad);
    RF_SEND = rf;
    RF_DATA = rd;
    ALU_SEND = alu;
    ALU_DATA = ad;
    tick();
    RF_SEND = 1'b0;
    ALU_SEND = 1'b0;
  endtask

  task automatic check_log(input string name, input int idx, input logic [7:0] exp);
    if (idx < wr_log.size()) check(name, 32'(wr_log[idx]), 32'(exp));
    else check({name, "_missing"}, 32'(wr_log.size()), 32'(idx + 1));
  endtask

  int t;

  initial begin
    // reset state
    repeat (3) tick();
    check("rst_wr_inc", 32'(WR_INC), 32'h0);
    check("rst_wr_data", 32'(WR_DATA), 32'h0);
    check("rst_busy", 32'(BUSY), 32'h0);
    check("rst_ovr", 32'(OVR), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    RST = 1'b1;
    repeat (2) tick();

    // single RF frame
    clear_logs();
    t = cyc;
    send(1'b1, 8'hA5, 1'b0, 16'h0);
    repeat (6) tick();
    check("rf_count", 32'(wr_log.size()), 32'd1);
    check_log("rf_data", 0, 8'hA5);
    if (wr_cyc.size() > 0) check("rf_latency", 32'(wr_cyc[0] - t), 32'd2);
    check("rf_busy_cycles", 32'(busy_cnt), 32'd1);

    // ALU pair
    clear_logs();
    t = cyc;
    send(1'b0, 8'h0, 1'b1, 16'h1234);
    repeat (6) tick();
    check("alu_count", 32'(wr_log.size()), 32'd2);
    check_log("alu_lsb", 0, 8'h34);
    check_log("alu_msb", 1, 8'h12);
    if (wr_cyc.size() > 1) begin
      check("alu_lsb_latency", 32'(wr_cyc[0] - t), 32'd2);
      check("alu_msb_latency", 32'(wr_cyc[1] - t), 32'd3);
    end

    // FIFO full stall starting on the LSB cycle
    clear_logs();
    t = cyc;
    send(1'b0, 8'h0, 1'b1, 16'hBEEF);
    tick();
    FIFO_FULL = 1'b1;
    repeat (5) tick();
    FIFO_FULL = 1'b0;
    repeat (5) tick();
    check("stall_count", 32'(wr_log.size()), 32'd2);
    check_log("stall_lsb", 0, 8'hEF);
    check_log("stall_msb", 1, 8'hBE);
    if (wr_cyc.size() > 0) check("stall_lsb_cycle", 32'(wr_cyc[0] - t), 32'd7);

    // simultaneous sends: RF first, then ALU pair
    clear_logs();
    send(1'b1, 8'h11, 1'b1, 16'h2233);
    repeat (8) tick();
    check("simul_count", 32'(wr_log.size()), 32'd3);
    check_log("simul_0", 0, 8'h11);
    check_log("simul_1", 1, 8'h33);
    check_log("simul_2", 2, 8'h22);
    check("simul_ovr", 32'(ovr_cnt), 32'd0);

    // RF overwrite while an ALU pair is in progress
    clear_logs();
    send(1'b0, 8'h0, 1'b1, 16'hABCD);
    tick();
    send(1'b1, 8'h44, 1'b0, 16'h0);
    send(1'b1, 8'h55, 1'b0, 16'h0);
    repeat (6) tick();
    check("ovr_pulses", 32'(ovr_cnt), 32'd1);
    check("ovr_count", 32'(wr_log.size()), 32'd3);
    check_log("ovr_0", 0, 8'hCD);
    check_log("ovr_1", 1, 8'hAB);
    check_log("ovr_2", 2, 8'h55);

    // send in the same cycle IDLE consumes the pend: no OVR, both delivered
    clear_logs();
    send(1'b1, 8'h66, 1'b0, 16'h0);
    send(1'b1, 8'h77, 1'b0, 16'h0);
    repeat (6) tick();
    check("consume_ovr", 32'(ovr_cnt), 32'd0);
    check("consume_count", 32'(wr_log.size()), 32'd2);
    check_log("consume_0", 0, 8'h66);
    check_log("consume_1", 1, 8'h77);

    // reset after the ALU LSB write
    clear_logs();
    send(1'b0, 8'h0, 1'b1, 16'hCAFE);
    tick();
    @(negedge CLK);
    #1;
    RST = 1'b0;
    #1;
    check("abort_wr_inc", 32'(WR_INC), 32'h0);
    check("abort_wr_data", 32'(WR_DATA), 32'h0);
    check("abort_busy", 32'(BUSY), 32'h0);
    check("abort_ovr", 32'(OVR), 32'h0);
    repeat (2) tick();
    RST = 1'b1;
    repeat (5) tick();
    check("abort_count", 32'(wr_log.size()), 32'd1);
    check_log("abort_lsb", 0, 8'hFE);
    clear_logs();
    t = cyc;
    send(1'b1, 8'h01, 1'b0, 16'h0);
    repeat (5) tick();
    check("after_rst_count", 32'(wr_log.size()), 32'd1);
    check_log("after_rst_data", 0, 8'h01);
    if (wr_cyc.size() > 0) check("after_rst_latency", 32'(wr_cyc[0] - t), 32'd2);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
